// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - state encoding, protocol constants and line symbols for usb_line_tx
// USB_TX_ABORT_EN adds the ABORT state.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
`ifdef USB_TX_ABORT_EN
        , S_ABORT = 3'd5
`endif
    } usb_tx_state_e;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam logic [2:0] EOP_SE0_BITS = 3'd2;

    // Line symbols packed as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// rtl/usb_tx_bit_timer.sv - divides clk down to one bit_tick per line bit, restartable
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // The tick marks the last cycle of the current symbol.
    assign bit_tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/usb_line_tx.sv
// rtl/usb_line_tx.sv - USB full-speed line transmitter: SYNC, bit stuffing, NRZI, EOP
// Define USB_TX_ABORT_EN to send a bit-stuff violation on underrun before EOP.
module usb_line_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_oe,
    output logic       done,
    output logic       err
);
    import usb_tx_pkg::*;

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_SYNC    = S_SYNC;
    localparam logic [2:0] ST_DATA    = S_DATA;
    localparam logic [2:0] ST_EOP_SE0 = S_EOP_SE0;
    localparam logic [2:0] ST_EOP_J   = S_EOP_J;
`ifdef USB_TX_ABORT_EN
    localparam logic [2:0] ST_ABORT   = S_ABORT;
`endif

    logic [2:0] state, state_n;
    logic [7:0] hold_data, hold_data_n, shreg, shreg_n;
    logic       hold_full, hold_full_n, hold_last, hold_last_n;
    logic       cur_last, cur_last_n;
    logic [2:0] bit_cnt, bit_cnt_n, ones_cnt, ones_n;
    logic       level, level_n;
    logic [1:0] line, line_n;
    logic       oe_n, done_n, err_n;
    logic       emit, emit_bit;
    logic       line_busy, accept, start, bit_tick;
    logic       next_avail, next_last;
    logic [7:0] next_byte;

`ifdef USB_TX_ABORT_EN
    assign line_busy = (state == ST_EOP_SE0) || (state == ST_EOP_J) || (state == ST_ABORT);
`else
    assign line_busy = (state == ST_EOP_SE0) || (state == ST_EOP_J);
`endif

    assign tx_ready   = !hold_full && !line_busy;
    assign accept     = tx_valid && tx_ready;
    assign start      = (state == ST_IDLE) && (hold_full || accept);
    // A byte arriving in the boundary cycle itself is taken straight from the input.
    assign next_avail = hold_full || accept;
    assign next_byte  = hold_full ? hold_data : tx_data;
    assign next_last  = hold_full ? hold_last : tx_last;

    usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (RST),
        .restart  (start),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        ones_n      = ones_cnt;
        level_n     = level;
        line_n      = line;
        oe_n        = tx_oe;
        cur_last_n  = cur_last;
        hold_full_n = hold_full;
        hold_data_n = hold_data;
        hold_last_n = hold_last;
        done_n      = 1'b0;
        err_n       = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;

        if (accept) begin
            hold_full_n = 1'b1;
            hold_data_n = tx_data;
            hold_last_n = tx_last;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_SYNC;
                    oe_n      = 1'b1;
                    bit_cnt_n = 3'd0;
                    ones_n    = 3'd0;
                    level_n   = 1'b1;
                    emit      = 1'b1;
                    emit_bit  = SYNC_PATTERN[0];
                end
            end
            ST_SYNC: begin
                if (bit_tick) begin
                    emit = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n     = ST_DATA;
                        shreg_n     = next_byte;
                        cur_last_n  = next_last;
                        hold_full_n = 1'b0;
                        bit_cnt_n   = 3'd0;
                        emit_bit    = next_byte[0];
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit_bit  = SYNC_PATTERN[bit_cnt + 3'd1];
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (ones_cnt == STUFF_LIMIT) begin
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit      = 1'b1;
                        emit_bit  = shreg[bit_cnt + 3'd1];
                    end else if (cur_last) begin
                        state_n   = ST_EOP_SE0;
                        bit_cnt_n = 3'd0;
                        line_n    = LINE_SE0;
                    end else if (next_avail) begin
                        shreg_n     = next_byte;
                        cur_last_n  = next_last;
                        hold_full_n = 1'b0;
                        bit_cnt_n   = 3'd0;
                        emit        = 1'b1;
                        emit_bit    = next_byte[0];
                    end else begin
                        err_n     = 1'b1;
                        bit_cnt_n = 3'd0;
`ifdef USB_TX_ABORT_EN
                        state_n   = ST_ABORT;
                        emit      = 1'b1;
                        emit_bit  = 1'b1;
`else
                        state_n   = ST_EOP_SE0;
                        line_n    = LINE_SE0;
`endif
                    end
                end
            end
`ifdef USB_TX_ABORT_EN
            ST_ABORT: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_n   = ST_EOP_SE0;
                        bit_cnt_n = 3'd0;
                        line_n    = LINE_SE0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit      = 1'b1;
                        emit_bit  = 1'b1;
                    end
                end
            end
`endif
            ST_EOP_SE0: begin
                if (bit_tick) begin
                    if (bit_cnt == EOP_SE0_BITS - 3'd1) begin
                        state_n = ST_EOP_J;
                        level_n = 1'b1;
                        line_n  = LINE_J;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_tick) begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                    line_n  = LINE_SE0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                oe_n    = 1'b0;
                line_n  = LINE_SE0;
            end
        endcase

        // NRZI: a 0 toggles the level, a 1 holds it and extends the run of ones.
        if (emit) begin
            level_n = emit_bit ? level_n : !level_n;
            line_n  = level_n ? LINE_J : LINE_K;
            ones_n  = emit_bit ? ones_n + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            shreg     <= 8'd0;
            hold_data <= 8'd0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
            cur_last  <= 1'b0;
            bit_cnt   <= 3'd0;
            ones_cnt  <= 3'd0;
            level     <= 1'b1;
            line      <= LINE_SE0;
            tx_oe     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            hold_last <= hold_last_n;
            cur_last  <= cur_last_n;
            bit_cnt   <= bit_cnt_n;
            ones_cnt  <= ones_n;
            level     <= level_n;
            line      <= line_n;
            tx_oe     <= oe_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    assign d_plus_out  = line[1];
    assign d_minus_out = line[0];

endmodule

// File: tb/tb_usb_line_tx.sv
// tb/tb_usb_line_tx.sv - directed bench for usb_line_tx with hand-computed line symbol strings
module tb_usb_line_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, d_plus_out, d_minus_out, tx_oe, done, err;

    always #5 clk = ~clk;

    usb_line_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .RST         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .d_plus_out  (d_plus_out),
        .d_minus_out (d_minus_out),
        .tx_oe       (tx_oe),
        .done        (done),
        .err         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic byte sym_char(input logic p, input logic m);
        case ({p, m})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    byte sym_q[$];
    int  err_pos_q[$];
    int  done_cnt = 0, done_fall_cnt = 0, err_cnt = 0, acc_cnt = 0, rdy_rise_cnt = 0;
    logic prev_oe = 1'b0, prev_rdy = 1'b1;

    initial forever begin
        @(negedge clk);
        if (err) begin
            err_cnt++;
            err_pos_q.push_back(sym_q.size());
        end
        if (done) begin
            done_cnt++;
            if (!tx_oe && prev_oe) done_fall_cnt++;
        end
        if (tx_valid && tx_ready) acc_cnt++;
        if (tx_oe && tx_ready && !prev_rdy) rdy_rise_cnt++;
        if (tx_oe) sym_q.push_back(sym_char(d_plus_out, d_minus_out));
        prev_oe  = tx_oe;
        prev_rdy = tx_ready;
    end

    logic [7:0] pkt [4];

    task automatic wait_accept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_accepted"}, 32'(ok), 1);
    endtask

    task automatic run_pkt(input string tag, input int n, input bit with_last,
                           input string exp, input int exp_err);
        int  base, d0, f0, e0, ep0, bad, pos;
        bit  fin;
        base = sym_q.size();
        d0   = done_cnt;
        f0   = done_fall_cnt;
        e0   = err_cnt;
        ep0  = err_pos_q.size();
        for (int i = 0; i < n; i++) begin
            tx_data  = pkt[i];
            tx_last  = with_last && (i == n - 1);
            tx_valid = 1'b1;
            wait_accept(tag);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'd0;
        fin = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            @(posedge clk);
            if (done_cnt != d0) fin = 1'b1;
        end
        @(posedge clk);
        check({tag, "_oe_cycles"}, sym_q.size() - base, exp.len() * CPB);
        bad = 0;
        for (int i = 0; i < exp.len() * CPB; i++)
            if (base + i >= sym_q.size() || sym_q[base + i] != exp[i / CPB]) bad++;
        check({tag, "_symbols_wrong"}, bad, 0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_done_at_oe_fall"}, done_fall_cnt - f0, 1);
        check({tag, "_err_pulses"}, err_cnt - e0, exp_err);
        if (exp_err != 0) begin
            pos = (err_pos_q.size() > ep0) ? err_pos_q[ep0] - base : -1;
            check({tag, "_err_cycle"}, pos, 16 * CPB);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_oe"}, 32'(tx_oe), 0);
        check({tag, "_d_plus"}, 32'(d_plus_out), 0);
        check({tag, "_d_minus"}, 32'(d_minus_out), 0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 1);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int a0, r0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        pkt[0] = 8'hA5;
        run_pkt("a5", 1, 1'b1, "KJKJKJKKKJJKJJKK00J", 0);

        pkt[0] = 8'hFF;
        run_pkt("ff", 1, 1'b1, "KJKJKJKKKKKKKJJJJ00J", 0);

        pkt[0] = 8'hFC;
        run_pkt("fc", 1, 1'b1, "KJKJKJKKJKKKKKKKJ00J", 0);

        pkt[0] = 8'hC3;
        pkt[1] = 8'h12;
        pkt[2] = 8'h34;
        a0 = acc_cnt;
        r0 = rdy_rise_cnt;
        run_pkt("three", 3, 1'b1, "KJKJKJKKKKJKJKKKJJKJJKJKJKKJJJKJ00J", 0);
        check("three_accepts", acc_cnt - a0, 3);
        check("three_ready_rises", rdy_rise_cnt - r0, 3);

        pkt[0] = 8'h69;
`ifdef USB_TX_ABORT_EN
        run_pkt("underrun", 1, 1'b0, "KJKJKJKKKJKKJJJKKKKKKKKK00J", 1);
`else
        run_pkt("underrun", 1, 1'b0, "KJKJKJKKKJKKJJJK00J", 1);
`endif

        tx_data  = 8'h5A;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        wait_accept("midrst_b0");
        tx_data  = 8'h12;
        tx_last  = 1'b1;
        wait_accept("midrst_b1");
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        check("midrst_pre_oe", 32'(tx_oe), 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        pkt[0] = 8'hA5;
        run_pkt("after_rst", 1, 1'b1, "KJKJKJKKKJJKJJKK00J", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usb_line_tx.md
# usb_line_tx

Host-side USB full-speed line transmitter. It accepts packet bytes over a valid/ready handshake and drives the D+/D- pair directly. It generates SYNC, serializes the bytes LSB-first, inserts stuff bits, NRZI-encodes, and ends the packet with EOP. It is the sending end for the device transceiver's RX chain (dpll, nrzi_decoder, bit_unstuffer, sipo), and serves as the host/bus-model driver in system benches.

## Interface
- CLKS_PER_BIT, default 4: clk cycles per line bit, minimum 2. 48 MHz clk gives 12 Mbps.
- clk  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- tx_data  in  8  packet byte (PID first), sent LSB-first.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  byte is the final byte of the packet.
- tx_ready  out  1  holding register empty; a byte is accepted when tx_valid && tx_ready.
- d_plus_out  out  1  D+ line level.
- d_minus_out  out  1  D- line level.
- tx_oe  out  1  1 while driving the line.
- done  out  1  one-cycle pulse when a packet completes.
- err  out  1  one-cycle pulse on underrun.

## Operation
- Line symbols: J = (1,0), K = (0,1), SE0 = (0,0). When tx_oe=0, both lines are driven 0.
- NRZI encoding: a 0 toggles J/K, a 1 holds the level. The encoder state resets to J at packet start.
- FSM states: IDLE, SYNC, DATA, EOP_SE0, EOP_J. ABORT exists only with the config macro.
- IDLE -> SYNC on the first accepted byte.
- SYNC: sends 8'h80 LSB-first (0000000 1), which appears on the line as KJKJKJKK.
- DATA: loads the shift register from the holding register at each byte boundary and sends 8 bits.
- At a byte boundary:
  - If the just-sent byte had tx_last set, go to EOP_SE0.
  - Else if the holding register is full, continue with the next byte.
  - Else it is an underrun: pulse err, then go to ABORT if compiled in, otherwise EOP_SE0.
- Stuffing:
  - The ones counter clears at SYNC start; SYNC's final 1 counts toward it.
  - After 6 consecutive 1s, insert one 0 bit, which clears the counter.
  - A stuff bit owed after the last data bit is sent before EOP.
  - Stuff bits do not advance the data bit counter.
- EOP_SE0 lasts 2 bit times. EOP_J lasts 1 bit time, after which the FSM goes to IDLE, tx_oe falls and done pulses.
- tx_ready = holding register empty && state not in {EOP_SE0, EOP_J, ABORT}. Bytes offered during EOP are not accepted.
- Reset values: tx_oe=0, d_plus_out=0, d_minus_out=0, tx_ready=1, done=0, err=0, state=IDLE, holding register empty.

## Timing
- A byte accepted in IDLE at cycle 0 gives tx_oe=1 and the first K from cycle 1.
- Each line symbol is held exactly CLKS_PER_BIT cycles. The bit timer restarts at packet start.
- tx_oe stays high for (8 + 8N + S + 3) × CLKS_PER_BIT cycles, where N = bytes and S = stuff bits.
- done asserts in the cycle tx_oe falls. A new tx_valid may be accepted in that same cycle and starts SYNC the next cycle.
- The holding register refills with a 1-cycle turnaround. tx_ready rises in the cycle after the shift-register load. Keeping the line continuous only requires a refill within 8 bit times.
- err pulses in the cycle the underrun is detected, at the byte boundary.
- RST asserted mid-packet forces all reset values immediately, with no EOP. The line goes undriven.

## Configuration
- USB_TX_ABORT_EN defined: an underrun enters ABORT.
  - ABORT sends eight unstuffed 1s as a deliberate bit-stuff violation, then goes to EOP_SE0.
  - tx_oe time grows by 8 bit times.
- Undefined: an underrun goes straight to EOP_SE0, so the packet ends truncated. err still pulses.

## Structure
- Package usb_tx_pkg holds:
  - the state enum;
  - SYNC_PATTERN = 8'h80;
  - STUFF_LIMIT = 6;
  - EOP_SE0_BITS = 2;
  - line-symbol constants J/K/SE0.
- One sub-module, usb_tx_bit_timer: a CLKS_PER_BIT divider with a restart input and a one-cycle bit_tick output.

## Test plan
- Single byte 8'hA5 with tx_last, CLKS_PER_BIT=4:
  - line = KJKJKJKK, then K J J K J J K K, then SE0 SE0 J;
  - tx_oe high 76 cycles;
  - done pulses once;
  - err=0.
- Byte 8'hFF with tx_last: one stuff 0 after the 5th data 1, giving 17 data-phase bits and tx_oe high 80 cycles.
- Byte 8'hFC with tx_last: the final six 1s are followed by a stuff 0 before SE0, giving tx_oe high 80 cycles.
- Three-byte packet 8'hC3, 8'h12, 8'h34 (last), with tx_valid held high:
  - tx_ready toggles once per byte;
  - the line is continuous with no gap;
  - tx_oe high 140 cycles.
- Underrun: send 8'h69 without tx_last, then no more bytes:
  - err pulses at the byte boundary;
  - without the macro, EOP follows immediately;
  - with USB_TX_ABORT_EN, eight held line bits precede SE0.
- Assert RST during the second data byte: all outputs are at reset values in the same cycle, and the next packet starts with clean SYNC and NRZI state.
